// File: rtl/weapons_bank.sv
// rtl/weapons_bank.sv - single fire-control channel: ammo, shot gap, auto/semi fire, optional heat lockout (WEAPONS_HEAT_EN)
module weapons_bank #(
    parameter int         AMMO_W        = 9,
    parameter int         HEAT_W        = 5,
    parameter int         GAP           = 4,
    parameter int         HEAT_PER_SHOT = 4,
    parameter int         HEAT_RESUME   = 8,
    parameter int         COOL_DIV      = 8,
    parameter logic [3:0] WEAPONS_MODE  = 4'b0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mode,
    input  logic              fire,
    input  logic              auto,
    input  logic              load_en,
    input  logic [AMMO_W-1:0] load_ammo,
    output logic              shot,
    output logic [AMMO_W-1:0] ammo,
    output logic [HEAT_W-1:0] heat,
    output logic              overheat,
    output logic              error,
    output logic [1:0]        state
);

    // Gap counter only ever holds GAP-1 down to 0.
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_GAP      = 2'd1,
        ST_OVERHEAT = 2'd2,
        ST_EMPTY    = 2'd3
    } wb_state_t;

    wb_state_t         state_q;
    wb_state_t         state_d;

    logic              fire_q;
    logic              shot_q;
    logic              shot_d;
    logic              error_q;
    logic              error_d;
    logic [AMMO_W-1:0] ammo_q;
    logic [AMMO_W-1:0] ammo_d;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_d;
    logic              shot_req;
    logic              lock_q;
    logic              lock_d;

`ifdef WEAPONS_HEAT_EN
    // Cool counter holds 0 .. COOL_DIV-1; reaching COOL_DIV is the wrap point.
    localparam int COOL_W = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
    localparam logic [COOL_W-1:0] COOL_LAST   = COOL_W'(COOL_DIV - 1);
    localparam logic [HEAT_W-1:0] HEAT_MAX    = '1;
    localparam logic [HEAT_W-1:0] HEAT_RES_V  = HEAT_W'(HEAT_RESUME);
    localparam logic [HEAT_W:0]   HEAT_STEP   = (HEAT_W+1)'(HEAT_PER_SHOT);

    logic [HEAT_W-1:0] heat_q;
    logic [HEAT_W-1:0] heat_d;
    logic [HEAT_W:0]   heat_sum;
    logic [COOL_W-1:0] cool_q;
    logic [COOL_W-1:0] cool_d;
    logic              over_q;
    logic              over_d;

    assign lock_q   = over_q;
    assign lock_d   = over_d;
    assign heat     = heat_q;
    assign overheat = over_q;
`else
    assign lock_q   = 1'b0;
    assign lock_d   = 1'b0;
    assign heat     = '0;
    assign overheat = 1'b0;
`endif

    assign shot  = shot_q;
    assign ammo  = ammo_q;
    assign error = error_q;
    assign state = state_q;

    // Decide whether a round leaves the barrel at this edge.
    always_comb begin
        shot_req = (mode == WEAPONS_MODE) && fire && (auto || !fire_q);
        shot_d   = shot_req && (ammo_q != '0) && (gap_q == '0) && !lock_q && !load_en;
    end

    // Ammo, gap and error next values; load wins over a shot and blocks it.
    always_comb begin
        ammo_d  = ammo_q;
        gap_d   = gap_q;
        error_d = (mode == WEAPONS_MODE) && fire && (ammo_q == '0) && !load_en;

        if (load_en) begin
            ammo_d = load_ammo;
        end else if (shot_d) begin
            ammo_d = ammo_q - AMMO_W'(1);
        end

        if (shot_d) begin
            gap_d = GAP_RELOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

`ifdef WEAPONS_HEAT_EN
    // Heat: saturating add per shot, one-unit decay per COOL_DIV quiet cycles, lockout hysteresis on the new value.
    always_comb begin
        heat_d   = heat_q;
        cool_d   = cool_q;
        over_d   = over_q;
        heat_sum = {1'b0, heat_q} + HEAT_STEP;

        if (shot_d) begin
            heat_d = (heat_sum > {1'b0, HEAT_MAX}) ? HEAT_MAX : heat_sum[HEAT_W-1:0];
            cool_d = '0;
        end else if (cool_q == COOL_LAST) begin
            cool_d = '0;
            if (heat_q != '0) begin
                heat_d = heat_q - HEAT_W'(1);
            end
        end else begin
            cool_d = cool_q + COOL_W'(1);
        end

        if (heat_d == HEAT_MAX) begin
            over_d = 1'b1;
        end else if (heat_d <= HEAT_RES_V) begin
            over_d = 1'b0;
        end
    end

    // Heat model registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            heat_q <= '0;
            cool_q <= '0;
            over_q <= 1'b0;
        end else begin
            heat_q <= heat_d;
            cool_q <= cool_d;
            over_q <= over_d;
        end
    end
`endif

    // Reported state is derived from the values the other registers take at the same edge.
    always_comb begin
        state_d = ST_READY;
        if (lock_d) begin
            state_d = ST_OVERHEAT;
        end else if (ammo_d == '0) begin
            state_d = ST_EMPTY;
        end else if (gap_d != '0) begin
            state_d = ST_GAP;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Trigger history, ammo, gap and registered pulse/error outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_q  <= 1'b0;
            shot_q  <= 1'b0;
            error_q <= 1'b0;
            ammo_q  <= '0;
            gap_q   <= '0;
        end else begin
            fire_q  <= fire;
            shot_q  <= shot_d;
            error_q <= error_d;
            ammo_q  <= ammo_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_weapons_bank.sv
// tb/tb_weapons_bank.sv - self-checking bench for weapons_bank against a cycle-count reference model
module tb_weapons_bank;

    localparam int AMMO_W   = 9;
    localparam int HEAT_W   = 5;
    localparam int GAP      = 4;
    localparam int HPS      = 4;
    localparam int RESUME   = 8;
    localparam int COOL_DIV = 8;
    localparam int HEAT_MAX = 31;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [3:0]        mode = 4'd0;
    logic              fire = 1'b0;
    logic              auto = 1'b0;
    logic              load_en = 1'b0;
    logic [AMMO_W-1:0] load_ammo = '0;
    logic              shot;
    logic [AMMO_W-1:0] ammo;
    logic [HEAT_W-1:0] heat;
    logic              overheat;
    logic              error;
    logic [1:0]        state;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expressed via absolute cycle numbers of shots, not counters.
    longint m_cyc = 0;
    longint m_last_shot = -100;
    longint m_quiet_start = 0;
    int     m_ammo = 0;
    int     m_heat = 0;
    bit     m_over = 0;
    bit     m_fire_prev = 0;
    bit     e_shot = 0;
    bit     e_err = 0;
    int     e_state = 3;

    localparam logic [18:0] RESET_VEC = {1'b0, 9'd0, 5'd0, 1'b0, 1'b0, 2'd3};

    weapons_bank #(
        .AMMO_W(AMMO_W), .HEAT_W(HEAT_W), .GAP(GAP), .HEAT_PER_SHOT(HPS),
        .HEAT_RESUME(RESUME), .COOL_DIV(COOL_DIV), .WEAPONS_MODE(4'b0010)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .fire(fire), .auto(auto),
        .load_en(load_en), .load_ammo(load_ammo), .shot(shot), .ammo(ammo),
        .heat(heat), .overheat(overheat), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] model_vec();
        logic [8:0] a;
        logic [4:0] h;
        logic [1:0] s;
        a = m_ammo[8:0];
        h = m_heat[4:0];
        s = e_state[1:0];
        return {e_shot, a, h, m_over, e_err, s};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {shot, ammo, heat, overheat, error, state};
    endfunction

    function automatic void model_reset();
        m_last_shot   = m_cyc - GAP;
        m_quiet_start = m_cyc;
        m_ammo = 0; m_heat = 0; m_over = 0; m_fire_prev = 0;
        e_shot = 0; e_err = 0; e_state = 3;
    endfunction

    // Predict the effect of the coming edge from current inputs, then advance past it.
    task automatic step();
        bit req;
        bit go;
        m_cyc++;
        req = (mode == 4'b0010) && fire && (auto || !m_fire_prev);
        go  = req && (m_ammo != 0) && (m_cyc - m_last_shot >= GAP) && !m_over && !load_en;
        e_err = (mode == 4'b0010) && fire && (m_ammo == 0) && !load_en;
        if (go) begin
            m_last_shot   = m_cyc;
            m_quiet_start = m_cyc;
        end
`ifdef WEAPONS_HEAT_EN
        if (go)
            m_heat = (m_heat + HPS > HEAT_MAX) ? HEAT_MAX : m_heat + HPS;
        else if (((m_cyc - m_quiet_start) % COOL_DIV) == 0 && m_heat > 0)
            m_heat--;
        if (m_heat == HEAT_MAX) m_over = 1;
        else if (m_heat <= RESUME) m_over = 0;
`endif
        if (load_en) m_ammo = int'(load_ammo);
        else if (go) m_ammo--;
        e_shot = go;
        m_fire_prev = fire;
        if (m_over) e_state = 2;
        else if (m_ammo == 0) e_state = 3;
        else if (m_cyc + 1 - m_last_shot < GAP) e_state = 1;
        else e_state = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] got;
        repeat (2) @(posedge clk);
        #1;
        got = dut_vec();
        if (got !== RESET_VEC) $display("FAIL reset_hold: got %h want %h", got, RESET_VEC);
        else n_pass++;
        n_checks++;
        rst = 1'b1;
        model_reset();
        load_en = 1; load_ammo = 9'd500;
        step();
        load_en = 0; mode = 4'b0010; auto = 1; fire = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL reset_burst: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
        end
        #3;
        rst = 1'b0;
        #1;
        got = dut_vec();
        if (got !== RESET_VEC) $display("FAIL reset_async: got %h want %h", got, RESET_VEC);
        else n_pass++;
        n_checks++;
        mode = 4'd0; fire = 0; auto = 0;
        @(posedge clk);
        #1;
        got = dut_vec();
        if (got !== RESET_VEC) $display("FAIL reset_edge: got %h want %h", got, RESET_VEC);
        else n_pass++;
        n_checks++;
        rst = 1'b1;
        model_reset();
    endtask

`ifdef WEAPONS_HEAT_EN
    longint last_shot_cyc;

    task automatic test_overheat();
        logic [18:0] got;
        int shots;
        int heats[8];
        longint prev;
        shots = 0; prev = 0;
        load_en = 1; load_ammo = 9'd500;
        step();
        load_en = 0; mode = 4'b0010; auto = 1; fire = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL overheat_cycle: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
            if (shot === 1'b1) begin
                if (shots < 8) heats[shots] = int'(heat);
                if (shots > 0) begin
                    if (m_cyc - prev != GAP) $display("FAIL overheat_spacing: got %0d want %0d", m_cyc - prev, GAP);
                    else n_pass++;
                    n_checks++;
                end
                prev = m_cyc;
                shots++;
            end
        end
        last_shot_cyc = prev;
        if (shots != 8) $display("FAIL overheat_shots: got %0d want 8", shots);
        else n_pass++;
        n_checks++;
        for (int k = 0; k < 8; k++) begin
            int want;
            want = (k < 7) ? 4 * (k + 1) : HEAT_MAX;
            if (heats[k] != want) $display("FAIL overheat_heat%0d: got %0d want %0d", k, heats[k], want);
            else n_pass++;
            n_checks++;
        end
        if (ammo !== 9'd492 || overheat !== 1'b1 || state !== 2'd2)
            $display("FAIL overheat_final: ammo %0d over %0d state %0d want 492 1 2", ammo, overheat, state);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_cooling();
        logic [18:0] got;
        bit cleared;
        cleared = 0;
        fire = 0;
        for (int i = 0; i < 400 && !cleared; i++) begin
            step();
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL cooling_cycle: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
            if (overheat === 1'b0) cleared = 1;
        end
        if (!cleared || m_cyc - last_shot_cyc != 184)
            $display("FAIL cooling_time: cleared %0d after %0d cycles want 184", cleared, m_cyc - last_shot_cyc);
        else n_pass++;
        n_checks++;
        if (heat !== 5'd8 || state !== 2'd0)
            $display("FAIL cooling_final: heat %0d state %0d want 8 0", heat, state);
        else n_pass++;
        n_checks++;
    endtask
`else
    task automatic test_no_heat();
        logic [18:0] got;
        int shots;
        shots = 0;
        load_en = 1; load_ammo = 9'd500;
        step();
        load_en = 0; mode = 4'b0010; auto = 1; fire = 1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (heat !== 5'd0 || overheat !== 1'b0)
                $display("FAIL noheat_zero: cyc %0d heat %0d over %0d want 0 0", m_cyc, heat, overheat);
            else n_pass++;
            n_checks++;
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL noheat_cycle: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
            if (shot === 1'b1) shots++;
        end
        if (shots != 20) $display("FAIL noheat_shots: got %0d want 20", shots);
        else n_pass++;
        n_checks++;
        fire = 0;
        step();
    endtask
`endif

    task automatic test_semi();
        logic [18:0] got;
        int shots;
        shots = 0;
        mode = 4'b0010; auto = 0; fire = 0;
        step();
        fire = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL semi_cycle: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
            if (shot === 1'b1) shots++;
        end
        if (shots != 1) $display("FAIL semi_held: got %0d shots want 1", shots);
        else n_pass++;
        n_checks++;
        fire = 0;
        step();
        fire = 1;
        step();
        if (shot !== 1'b1) $display("FAIL semi_retrigger: shot %0d want 1", shot);
        else n_pass++;
        n_checks++;
        fire = 0;
        step();
    endtask

    task automatic test_last_round();
        logic [18:0] got;
        int shots;
        shots = 0;
        load_en = 1; load_ammo = 9'd2;
        step();
        load_en = 0; mode = 4'b0010; auto = 1; fire = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL last_cycle: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
            if (shot === 1'b1) shots++;
        end
        if (shots != 2 || ammo !== 9'd0 || state !== 2'd3 || error !== 1'b1)
            $display("FAIL last_empty: shots %0d ammo %0d state %0d error %0d want 2 0 3 1", shots, ammo, state, error);
        else n_pass++;
        n_checks++;
        load_en = 1; load_ammo = 9'd10;
        step();
        if (error !== 1'b0 || ammo !== 9'd10)
            $display("FAIL last_reload: error %0d ammo %0d want 0 10", error, ammo);
        else n_pass++;
        n_checks++;
        load_en = 0; fire = 0;
        step();
    endtask

    task automatic test_mode_gate();
        logic [18:0] got;
        mode = 4'b0001; auto = 1; fire = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 15) load_en = 1;
            if (i == 15) load_ammo = 9'd0;
            if (i == 16) load_en = 0;
            step();
            if (shot !== 1'b0 || error !== 1'b0)
                $display("FAIL mode_gate: cyc %0d shot %0d error %0d want 0 0", m_cyc, shot, error);
            else n_pass++;
            n_checks++;
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL mode_cycle: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
        end
        fire = 0; mode = 4'd0;
        step();
    endtask

    task automatic test_random();
        logic [18:0] got;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) auto = $urandom_range(0, 1);
            mode      = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010;
            fire      = ($urandom_range(0, 3) != 0);
            load_en   = ($urandom_range(0, 39) == 0);
            load_ammo = 9'($urandom_range(0, 40));
            step();
            got = dut_vec();
            if (got !== model_vec()) $display("FAIL random_cycle: cyc %0d got %h want %h", m_cyc, got, model_vec());
            else n_pass++;
            n_checks++;
        end
        load_en = 0; fire = 0;
    endtask

    initial begin
        test_reset();
`ifdef WEAPONS_HEAT_EN
        test_overheat();
        test_cooling();
`else
        test_no_heat();
`endif
        test_semi();
        test_last_round();
        test_mode_gate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
